// File: rtl/mux_scan_pkg.sv
// Shared types for the 4:1 mux scan sequencer: FSM states, channel index
// and the settle-counter width.
package mux_scan_pkg;

  localparam int CNT_W = 4;

  typedef logic [1:0] ch_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mux_scan_sequencer_settle_timer.sv
// Settle countdown: loads a start value, counts down while enabled and
// flags zero; it holds at zero rather than wrapping.
module settle_timer
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux through its four channels, holds each select for SETTLE
// cycles, samples Y and publishes the four samples as one snapshot.
//
//   state  | meaning
//   IDLE   | waiting for start, selects hold their last value
//   SETTLE | select applied, counting down the settle time
//   SAMPLE | Y captured into shadow[ch]
//   DONE   | snapshot published, done pulsed; cont restarts the scan
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       Y,
  output logic       S0,
  output logic       S1,
  output logic       busy,
  output logic       done,
  output logic [3:0] snapshot
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  state_t     state, state_nxt;
  ch_t        ch, ch_nxt;
  logic [3:0] shadow;
  logic       tmr_load, tmr_en, tmr_zero;
  logic       enter_settle, enter_done;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (RELOAD),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    unique case (state)
      mux_scan_pkg::IDLE: begin
        if (start) begin
          state_nxt = mux_scan_pkg::SETTLE;
          ch_nxt    = 2'd0;
          tmr_load  = 1'b1;
        end
      end
      mux_scan_pkg::SETTLE: begin
        if (tmr_zero) state_nxt = mux_scan_pkg::SAMPLE;
        else          tmr_en    = 1'b1;
      end
      mux_scan_pkg::SAMPLE: begin
        if (ch == 2'd3) begin
          state_nxt = mux_scan_pkg::DONE;
        end else begin
          state_nxt = mux_scan_pkg::SETTLE;
          ch_nxt    = ch + 2'd1;
          tmr_load  = 1'b1;
        end
      end
      mux_scan_pkg::DONE: begin
        ch_nxt = 2'd0;
        if (cont) begin
          state_nxt = mux_scan_pkg::SETTLE;
          tmr_load  = 1'b1;
        end else begin
          state_nxt = mux_scan_pkg::IDLE;
        end
      end
    endcase
  end

  assign enter_settle = (state_nxt == mux_scan_pkg::SETTLE) && (state != mux_scan_pkg::SETTLE);
  assign enter_done   = (state == mux_scan_pkg::SAMPLE) && (state_nxt == mux_scan_pkg::DONE);

  // Channel 3 is captured on the same edge that publishes the snapshot,
  // so its bit comes straight from Y rather than from shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= mux_scan_pkg::IDLE;
      ch       <= 2'd0;
      shadow   <= 4'b0000;
      S0       <= 1'b0;
      S1       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      snapshot <= 4'b0000;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
      busy  <= (state_nxt != mux_scan_pkg::IDLE);
      done  <= enter_done;
      if (state == mux_scan_pkg::SAMPLE) shadow[ch] <= Y;
      if (enter_settle) {S0, S1} <= ch_nxt;
      if (enter_done) snapshot <= {Y, shadow[2:0]};
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Drives two sequencers (SETTLE=1 and SETTLE=3) behind behavioural 4:1 muxes
// and compares them every cycle against a scan-timing reference model.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] a = 4'b0000;
  logic [1:0] s0, s1, y, busy, done;
  logic [3:0] snap [2];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // downstream 4:1 muxes: index {S0,S1} picks A0..A3
  assign y[0] = a[{s0[0], s1[0]}];
  assign y[1] = a[{s0[1], s1[1]}];

  mux_scan_sequencer #(.SETTLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .Y(y[0]),
    .S0(s0[0]), .S1(s1[0]), .busy(busy[0]), .done(done[0]), .snapshot(snap[0])
  );

  mux_scan_sequencer #(.SETTLE(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .Y(y[1]),
    .S0(s0[1]), .S1(s1[1]), .busy(busy[1]), .done(done[1]), .snapshot(snap[1])
  );

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // reference: a scan started by start seen in cycle t samples channel c at
  // the end of cycle t+(c+1)(s+1) and reports in cycle t+4(s+1)+1
  int         k = 0;
  int         m_t   [2] = '{0, 0};
  bit         m_act [2] = '{1'b0, 1'b0};
  logic [3:0] m_sh  [2] = '{4'b0, 4'b0};
  logic [3:0] m_snap[2] = '{4'b0, 4'b0};
  logic       m_done[2] = '{1'b0, 1'b0};
  logic [1:0] m_sel [2] = '{2'b0, 2'b0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0; m_sh[i] = 4'b0; m_snap[i] = 4'b0;
        m_done[i] = 1'b0; m_sel[i] = 2'b0;
      end
    end else begin
      k++;
      for (int i = 0; i < 2; i++) begin
        int p, d;
        p = settle_of(i) + 1;
        m_done[i] = 1'b0;
        if (m_act[i]) begin
          d = m_t[i] + 4 * p + 1;
          for (int c = 0; c < 4; c++)
            if (k == m_t[i] + (c + 1) * p + 1) m_sh[i][c] = a[c];
          if (k == d) begin
            m_snap[i] = m_sh[i];
            m_done[i] = 1'b1;
          end else if (k == d + 1) begin
            if (cont) m_t[i] = k - 1;
            else      m_act[i] = 1'b0;
          end
        end else if (start) begin
          m_act[i] = 1'b1;
          m_t[i]   = k - 1;
        end
        if (m_act[i] && (k < m_t[i] + 4 * p + 1))
          m_sel[i] = 2'((k - m_t[i] - 1) / p);
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy%0d", i), 8'(busy[i]), 8'(m_act[i]));
      chk($sformatf("done%0d", i), 8'(done[i]), 8'(m_done[i]));
      chk($sformatf("snap%0d", i), 8'(snap[i]), 8'(m_snap[i]));
      chk($sformatf("sel%0d", i), 8'({s0[i], s1[i]}), 8'(m_sel[i]));
    end
  endtask

  task automatic step(input logic st, input logic ct, input logic [3:0] av);
    @(negedge clk);
    check_cycle();
    start = st;
    cont  = ct;
    a     = av;
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    check_cycle();
    #2 rst_n = 1'b0;
    #1;
    check_cycle();
    chk("rst_snap0", 8'(snap[0]), 8'h00);
    chk("rst_busy1", 8'(busy[1]), 8'h00);
    @(negedge clk);
    check_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int nd0, nd1;
    repeat (2) @(negedge clk);
    check_cycle();
    rst_n = 1'b1;

    // single scan, A=1,0,1,1 with a stray start mid-scan
    nd0 = 0; nd1 = 0;
    step(1'b1, 1'b0, 4'b1101);
    for (int c = 1; c < 22; c++) begin
      step(c == 4, 1'b0, 4'b1101);
      nd0 += int'(done[0]);
      nd1 += int'(done[1]);
    end
    chk("one_scan_snap0", 8'(snap[0]), 8'h0d);
    chk("one_scan_snap1", 8'(snap[1]), 8'h0d);
    chk("one_scan_ndone0", 8'(nd0), 8'd1);
    chk("one_scan_ndone1", 8'(nd1), 8'd1);

    // A=0,1,0,0 with the slower instance in focus
    step(1'b1, 1'b0, 4'b0010);
    for (int c = 1; c < 22; c++) step(1'b0, 1'b0, 4'b0010);
    chk("a1_only_snap1", 8'(snap[1]), 8'h02);

    // continuous mode with A3 toggling every cycle
    step(1'b1, 1'b1, 4'b1010);
    for (int c = 1; c < 60; c++) step(1'b0, 1'b1, {c[0], 3'b010});
    step(1'b0, 1'b0, 4'b0000);
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 4'($urandom));

    // reset in the middle of a scan
    step(1'b1, 1'b0, 4'b1111);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 4'b1111);
    reset_mid_cycle();
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 4'b1111);
    chk("post_rst_snap1", 8'(snap[1]), 8'h00);

    // random traffic
    for (int c = 0; c < 700; c++) begin
      step(($urandom % 6) == 0, ($urandom % 3) == 0, 4'($urandom));
      if (($urandom % 180) == 0) reset_mid_cycle();
    end
    step(1'b0, 1'b0, 4'b0000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, range 1..15: cycles held on each select value before sampling Y.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, scan request, sampled only in IDLE.
REQ-005 The block SHALL have port cont, input, 1, continuous mode, sampled in DONE.
REQ-006 The block SHALL have port Y, input, 1, output of the downstream 4:1 mux.
REQ-007 The block SHALL have ports S0 and S1, output, 1 each, registered mux selects.
REQ-008 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse when a scan completes.
REQ-010 The block SHALL have port snapshot, output, 4, where bit i is the Y value sampled with channel i selected.

Function
REQ-011 Channel index ch[1:0] SHALL map to the mux as S0=ch[1], S1=ch[0]: 00 selects A0, 01 selects A1, 10 selects A2, 11 selects A3.
REQ-012 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-013 IDLE with start=1 SHALL go to SETTLE with ch=0, settle counter=SETTLE-1; start=0 SHALL hold IDLE.
REQ-014 SETTLE SHALL decrement the counter each cycle and go to SAMPLE in the cycle after it reads 0, so the select is stable for exactly SETTLE cycles before sampling.
REQ-015 SAMPLE SHALL write Y into shadow[ch] (one cycle).
REQ-016 From SAMPLE, ch<3 SHALL increment ch, reload the counter and go to SETTLE; ch=3 SHALL go to DONE.
REQ-017 On entry to DONE, snapshot SHALL load shadow; done=1 for that single cycle only.
REQ-018 From DONE, cont=1 SHALL restart at SETTLE with ch=0; cont=0 SHALL go to IDLE with ch holding 0.
REQ-019 With start at cycle T, channel i SHALL be sampled at cycle T+(i+1)(SETTLE+1), and done SHALL be high at T+4(SETTLE+1)+1.
REQ-020 In continuous mode, done SHALL repeat every 4(SETTLE+1)+1 cycles.
REQ-021 start asserted while busy=1 SHALL be ignored, neither queued nor restarting the scan.
REQ-022 snapshot SHALL change only on entry to DONE, never mid-scan.
REQ-023 S0/S1 SHALL change only on the transition into SETTLE and remain constant through SETTLE and SAMPLE.

Reset
REQ-024 Asserting rst_n low SHALL immediately force state=IDLE, ch=0, S0=S1=0, busy=0, done=0, snapshot=4'b0000, shadow=0 and counter=0, regardless of clock.
REQ-025 Reset mid-scan SHALL discard the partial shadow; no done SHALL follow.
REQ-026 After rst_n deasserts, the first start SHALL be honoured on the first rising edge at which it is seen.

Structure
REQ-027 Package mux_scan_pkg SHALL hold the state enum (IDLE, SETTLE, SAMPLE, DONE), the 2-bit channel type and the 4-bit counter width constant.
REQ-028 The settle countdown SHALL be a sub-module settle_timer with inputs load, load value and enable, and output zero.
REQ-029 The top level SHALL contain only the FSM, the channel counter, the shadow register and the output registers.

Verification
REQ-030 The bench SHALL instantiate the existing 4:1 mux behind the DUT, wiring S0/S1 from the DUT and Y back to it.
REQ-031 Scenario: SETTLE=1, A0..A3=1,0,1,1, start pulse at T -> done at T+9, snapshot=4'b1101, busy high T+1..T+9.
REQ-032 Scenario: SETTLE=3, A=0,1,0,0 -> each select held 3 cycles before its sample; done at T+17; snapshot=4'b0010.
REQ-033 Scenario: cont=1, A3 toggled between scans -> done pulses 9 cycles apart; snapshot[3] tracks A3 per scan.
REQ-034 Scenario: start pulsed at T+4 during a scan -> ignored; exactly one done, at T+9.
REQ-035 Scenario: rst_n low at T+5 mid-scan -> outputs at reset values within the same cycle, no done, snapshot=0.
REQ-036 Scenario: A2 toggled during SETTLE with ch=2 but stable at SAMPLE -> snapshot[2] equals the value at the SAMPLE cycle.
